serial_decoder: RTL
===================

SERIAL_DECODER -- requirements
Module: serial_decoder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the number of data bits per frame (legal range 2..16).
REQ-002 Parameter LSB_FIRST, default 1, SHALL select bit order: 1 = bit0 first (matches the team's PISO encoder), 0 = MSB first.
REQ-003 Port clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port serialIn  input  1  SHALL carry one serial data bit per clock cycle.
REQ-006 Port frameStart  input  1  SHALL mark the cycle in which serialIn carries the first bit of a frame.
REQ-007 Port parallelOut  output  DATA_WIDTH  SHALL hold the last completed word (registered).
REQ-008 Port dataValid  output  1  SHALL pulse high for one cycle when parallelOut is updated.
REQ-009 Port frameAbort  output  1  SHALL pulse high for one cycle when a partial frame is discarded.
REQ-010 Port parityError  output  1  SHALL pulse high with dataValid when the received parity bit mismatches (see Configuration).

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and PARITY; PARITY exists only when PARITY_EN is defined.
REQ-012 In IDLE, frameStart=1 SHALL capture serialIn as data bit 0 of the frame, load the bit counter with 1 and enter SHIFT; frameStart=0 SHALL leave the FSM in IDLE and ignore serialIn.
REQ-013 In SHIFT, each cycle SHALL capture serialIn into the shift register at the position given by LSB_FIRST and increment the bit counter.
REQ-014 When the DATA_WIDTH-th bit is captured, the FSM SHALL go to IDLE (no parity) or PARITY (PARITY_EN).
REQ-015 Word completion SHALL load parallelOut and assert dataValid in the cycle immediately after the edge sampling the final frame bit (data bit or parity bit): 1-cycle latency.
REQ-016 dataValid and frameAbort SHALL be single-cycle pulses; they SHALL never be asserted in the same cycle.
REQ-017 parallelOut SHALL hold its value between completions; partial frames SHALL never be visible on it.
REQ-018 frameStart=1 while in SHIFT or PARITY SHALL discard the partial frame, pulse frameAbort, and treat serialIn in that cycle as bit 0 of a new frame (remain/enter SHIFT, counter=1).
REQ-019 frameStart=1 in the cycle after the final frame bit (back-to-back frames, zero gap) SHALL be accepted as a normal start with no frameAbort.
REQ-020 The bit counter SHALL be ceil(log2(DATA_WIDTH+1)) bits and SHALL never exceed DATA_WIDTH (no wrap-around).

Reset
REQ-021 reset=1 SHALL, at the next rising clock edge, force IDLE, bit counter 0, shift register 0, parallelOut 0, dataValid 0, frameAbort 0, parityError 0.
REQ-022 reset SHALL take priority over frameStart; a frame in progress when reset asserts SHALL be dropped silently (no frameAbort, no dataValid).
REQ-023 The first frameStart accepted SHALL be in the first cycle with reset=0.

Configuration
REQ-024 Macro SERIAL_DECODER_PARITY_EN defined: each frame SHALL carry one even-parity bit after the data bits; parityError SHALL equal (XOR of data bits XOR parity bit) for that frame, and parallelOut/dataValid SHALL still update.
REQ-025 Macro SERIAL_DECODER_PARITY_EN undefined: frames SHALL be DATA_WIDTH bits only, PARITY state SHALL not exist, and parityError SHALL be tied to 0.

Verification
REQ-026 Reset, then frameStart with bits 1,0,1,0,0,1,0,1 (LSB_FIRST=1) -> parallelOut=0xA5, dataValid=1 for exactly one cycle, 1 cycle after the 8th bit.
REQ-027 Two back-to-back frames 0x3C then 0xFF, zero gap -> two dataValid pulses 8 cycles apart, values 0x3C then 0xFF, frameAbort never asserted.
REQ-028 frameStart after 5 bits of 0x12, then full frame 0x81 -> frameAbort pulse at the restart, one dataValid with 0x81, parallelOut unchanged until then.
REQ-029 reset asserted at bit 4 of a frame -> all outputs 0 next cycle, no dataValid/frameAbort; subsequent frame 0x5A decodes correctly.
REQ-030 PARITY_EN: frame 0x07 with parity 1 -> parityError=0; same data with parity 0 -> parityError=1 with dataValid, parallelOut=0x07.
REQ-031 LSB_FIRST=0: bits 1,0,0,0,0,0,0,0 -> parallelOut=0x80.

Source files
------------

// File: rtl/serial_decoder.sv
// Serial-to-parallel frame decoder: frameStart marks bit 0, word registered one cycle after its last bit.
// Optional even-parity trailer bit enabled by defining SERIAL_DECODER_PARITY_EN.
module serial_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serialIn,
  input  logic                  frameStart,
  output logic [DATA_WIDTH-1:0] parallelOut,
  output logic                  dataValid,
  output logic                  frameAbort,
  output logic                  parityError
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

`ifdef SERIAL_DECODER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic {IDLE, SHIFT} state_e;
`endif

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  vld_q, vld_d;
  logic                  abort_q, abort_d;
  logic [DATA_WIDTH-1:0] word, first;
`ifdef SERIAL_DECODER_PARITY_EN
  logic                  perr_q, perr_d;
`endif

  // After exactly DATA_WIDTH shifts the first bit lands at bit 0 (LSB first) or the MSB.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] base,
                                                     input logic b);
    if (LSB_FIRST) return {b, base[DATA_WIDTH-1:1]};
    else           return {base[DATA_WIDTH-2:0], b};
  endfunction

  assign word  = shift_in(sh_q, serialIn);
  assign first = shift_in('0, serialIn);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    abort_d = 1'b0;
`ifdef SERIAL_DECODER_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (frameStart) begin
      // A start always begins a new frame; mid-frame it discards the partial one.
      abort_d = (state_q != IDLE);
      state_d = SHIFT;
      sh_d    = first;
      cnt_d   = CW'(1);
    end else begin
      case (state_q)
        IDLE: ;
        SHIFT: begin
          sh_d  = word;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
`ifdef SERIAL_DECODER_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            out_d   = word;
            vld_d   = 1'b1;
`endif
          end
        end
`ifdef SERIAL_DECODER_PARITY_EN
        PARITY: begin
          state_d = IDLE;
          out_d   = sh_q;
          vld_d   = 1'b1;
          perr_d  = (^sh_q) ^ serialIn;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      abort_q <= 1'b0;
`ifdef SERIAL_DECODER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      abort_q <= abort_d;
`ifdef SERIAL_DECODER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign parallelOut = out_q;
  assign dataValid   = vld_q;
  assign frameAbort  = abort_q;
`ifdef SERIAL_DECODER_PARITY_EN
  assign parityError = perr_q;
`else
  assign parityError = 1'b0;
`endif
endmodule
